// File: rtl/spi_data_bank.sv
// spi_data_bank: shared host/SPI-engine data memory with auto-incrementing TX/RX pointers
module spi_data_bank #(
    parameter int DEPTH = 32,
    parameter int DW = 32,
    parameter int SW = 8,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold_ctrl,
    input  logic [AW-1:0] host_addr,
    input  logic          host_we,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_re,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic          host_err,
    input  logic          eng_ptr_clr,
    input  logic          eng_tx_req,
    output logic [SW-1:0] eng_tx_data,
    output logic          eng_tx_valid,
    output logic          eng_tx_last,
    input  logic [AW-1:0] tx_last_idx,
    input  logic          eng_rx_we,
    input  logic [SW-1:0] eng_rx_data,
    output logic          eng_err,
    output logic [AW:0]   rx_count,
    output logic          rx_ovf
);
    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] tx_ptr, rx_ptr;
    logic rvalid_q, host_err_q, tx_valid_q, tx_last_q, eng_err_q;
    logic host_wr, eng_go, tx_go, rx_go, full;
    // Qualify strobes by ownership; a pointer clear drops engine requests
    always_comb begin
        host_wr = host_we & ~hold_ctrl;
        eng_go  = hold_ctrl & ~eng_ptr_clr;
        tx_go   = eng_tx_req & eng_go;
        rx_go   = eng_rx_we & eng_go;
        full    = rx_count == FULL;
    end
    // Storage: host and engine writes are exclusive by ownership
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (host_wr) begin
            mem[host_addr] <= host_wdata;
        end else if (rx_go) begin
            mem[rx_ptr] <= DW'(eng_rx_data);
        end
    end
    // Host port: registered reads always allowed, rejected writes flagged
    always_ff @(posedge clk) begin
        if (rst) begin
            host_rdata <= '0;
            rvalid_q   <= 1'b0;
            host_err_q <= 1'b0;
        end else begin
            if (host_re) host_rdata <= mem[host_addr];
            rvalid_q   <= host_re;
            host_err_q <= host_we & hold_ctrl;
        end
    end
    // Engine port: pointer streaming, fill count and overflow tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ptr      <= '0;
            rx_ptr      <= '0;
            rx_count    <= '0;
            rx_ovf      <= 1'b0;
            eng_tx_data <= '0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            eng_err_q   <= 1'b0;
        end else begin
            tx_valid_q <= tx_go;
            tx_last_q  <= tx_go & (tx_ptr == tx_last_idx);
            eng_err_q  <= ~hold_ctrl & ~eng_ptr_clr & (eng_tx_req | eng_rx_we);
            if (tx_go) eng_tx_data <= mem[tx_ptr][SW-1:0];
            if (eng_ptr_clr) begin
                tx_ptr   <= '0;
                rx_ptr   <= '0;
                rx_count <= '0;
                rx_ovf   <= 1'b0;
            end else begin
                if (tx_go) tx_ptr <= tx_ptr + 1'b1;
                if (rx_go) begin
                    rx_ptr   <= rx_ptr + 1'b1;
                    rx_count <= full ? FULL : rx_count + 1'b1;
                    rx_ovf   <= rx_ovf | full;
                end
            end
        end
    end
    // Pulses are masked while reset is held so outstanding ones never escape
    always_comb begin
        host_rvalid  = rvalid_q & ~rst;
        host_err     = host_err_q & ~rst;
        eng_tx_valid = tx_valid_q & ~rst;
        eng_tx_last  = tx_last_q & ~rst;
        eng_err      = eng_err_q & ~rst;
    end
endmodule

// File: tb/tb_spi_data_bank.sv
// tb_spi_data_bank: table, directed and random checks of spi_data_bank against a reference model
module tb_spi_data_bank;
    localparam int DEPTH = 32;
    logic clk = 1'b0, rst = 1'b1, hold_ctrl = 1'b0;
    logic [4:0] host_addr = '0, tx_last_idx = '0;
    logic host_we = 1'b0, host_re = 1'b0, eng_ptr_clr = 1'b0, eng_tx_req = 1'b0, eng_rx_we = 1'b0;
    logic [31:0] host_wdata = '0, host_rdata;
    logic [7:0] eng_rx_data = '0, eng_tx_data;
    logic host_rvalid, host_err, eng_tx_valid, eng_tx_last, eng_err, rx_ovf;
    logic [5:0] rx_count;
    int total = 0, bad = 0;
    logic [31:0] m_mem [DEPTH];
    int m_tx, m_rx, m_cnt;
    logic m_ovf, e_rvalid, e_herr, e_txv, e_txl, e_eerr;
    logic [31:0] e_rdata;
    logic [7:0] e_txd;
    typedef struct {
        logic hold, we, re, txreq, rxwe, clr;
        logic [4:0] addr, last;
        logic [31:0] wdata;
        logic [7:0] rxd;
        logic [31:0] x_rdata;
        logic x_rv, x_herr, x_txv, x_txl, x_eerr;
        logic [7:0] x_txd;
        logic [5:0] x_cnt;
    } vec_t;
    vec_t vt [16];

    spi_data_bank #(.DEPTH(DEPTH), .DW(32), .SW(8)) dut (
        .clk(clk), .rst(rst), .hold_ctrl(hold_ctrl), .host_addr(host_addr), .host_we(host_we),
        .host_wdata(host_wdata), .host_re(host_re), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .host_err(host_err), .eng_ptr_clr(eng_ptr_clr), .eng_tx_req(eng_tx_req), .eng_tx_data(eng_tx_data),
        .eng_tx_valid(eng_tx_valid), .eng_tx_last(eng_tx_last), .tx_last_idx(tx_last_idx),
        .eng_rx_we(eng_rx_we), .eng_rx_data(eng_rx_data), .eng_err(eng_err), .rx_count(rx_count), .rx_ovf(rx_ovf)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural view of one clock edge: reads see pre-edge contents, pointers wrap modulo DEPTH
    task automatic model_step();
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            {m_tx, m_rx, m_cnt} = '0;
            {m_ovf, e_rvalid, e_herr, e_txv, e_txl, e_eerr} = '0;
            e_rdata = '0;
            e_txd = '0;
        end else begin
            e_rvalid = host_re;
            if (host_re) e_rdata = m_mem[host_addr];
            e_herr = host_we & hold_ctrl;
            {e_txv, e_txl, e_eerr} = '0;
            if (eng_ptr_clr) begin
                {m_tx, m_rx, m_cnt} = '0;
                m_ovf = 1'b0;
            end else if (!hold_ctrl) begin
                e_eerr = eng_tx_req | eng_rx_we;
            end else begin
                if (eng_tx_req) begin
                    e_txd = m_mem[m_tx][7:0];
                    e_txv = 1'b1;
                    e_txl = (m_tx == int'(tx_last_idx));
                    m_tx = (m_tx + 1) % DEPTH;
                end
                if (eng_rx_we) begin
                    m_mem[m_rx] = {24'h0, eng_rx_data};
                    if (m_cnt == DEPTH) m_ovf = 1'b1;
                    m_cnt = (m_cnt == DEPTH) ? DEPTH : m_cnt + 1;
                    m_rx = (m_rx + 1) % DEPTH;
                end
            end
            if (host_we && !hold_ctrl) m_mem[host_addr] = host_wdata;
        end
    endtask

    task automatic check_all();
        chk("host_rvalid", host_rvalid, e_rvalid & ~rst);
        chk("host_rdata", host_rdata, e_rdata);
        chk("host_err", host_err, e_herr & ~rst);
        chk("eng_tx_valid", eng_tx_valid, e_txv & ~rst);
        chk("eng_tx_last", eng_tx_last, e_txl & ~rst);
        chk("eng_tx_data", eng_tx_data, e_txd);
        chk("eng_err", eng_err, e_eerr & ~rst);
        chk("rx_count", rx_count, m_cnt);
        chk("rx_ovf", rx_ovf, m_ovf);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        {host_we, host_re, eng_ptr_clr, eng_tx_req, eng_rx_we} = '0;
    endtask

    initial begin
        vt[0]  = '{0,1,0,0,0,0, 0,0,'h11,0,    0,0,0,0,0,0,'h00,0};
        vt[1]  = '{0,1,0,0,0,0, 1,0,'h22,0,    0,0,0,0,0,0,'h00,0};
        vt[2]  = '{0,1,0,0,0,0, 2,0,'h33,0,    0,0,0,0,0,0,'h00,0};
        vt[3]  = '{1,0,0,1,0,0, 0,2,0,0,       0,0,0,1,0,0,'h11,0};
        vt[4]  = '{1,0,0,1,0,0, 0,2,0,0,       0,0,0,1,0,0,'h22,0};
        vt[5]  = '{1,0,0,1,0,0, 0,2,0,0,       0,0,0,1,1,0,'h33,0};
        vt[6]  = '{1,0,0,1,0,0, 0,2,0,0,       0,0,0,1,0,0,'h00,0};
        vt[7]  = '{1,0,1,0,0,0, 2,2,0,0,       'h33,1,0,0,0,0,'h00,0};
        vt[8]  = '{1,1,0,0,0,0, 4,2,'hDEAD,0,  'h33,0,1,0,0,0,'h00,0};
        vt[9]  = '{1,0,1,0,0,0, 4,2,0,0,       0,1,0,0,0,0,'h00,0};
        vt[10] = '{0,0,0,0,1,0, 0,2,0,'h77,    0,0,0,0,0,1,'h00,0};
        vt[11] = '{0,0,0,1,1,0, 0,2,0,'h77,    0,0,0,0,0,1,'h00,0};
        vt[12] = '{1,0,0,0,1,0, 0,2,0,'h77,    0,0,0,0,0,0,'h00,1};
        vt[13] = '{1,0,1,0,0,0, 0,2,0,0,       'h77,1,0,0,0,0,'h00,1};
        vt[14] = '{1,0,0,1,0,1, 0,2,0,0,       'h77,0,0,0,0,0,'h00,0};
        vt[15] = '{1,0,0,1,0,0, 0,2,0,0,       'h77,0,0,1,0,0,'h77,0};
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            host_re = 1'b1;
            host_addr = 5'(a);
            tick();
            chk("reset_read_rvalid", host_rvalid, 1'b1);
            chk("reset_read_data", host_rdata, 32'h0);
        end
        idle();
        for (int v = 0; v < 16; v++) begin
            {hold_ctrl, host_we, host_re, eng_tx_req, eng_rx_we, eng_ptr_clr} =
                {vt[v].hold, vt[v].we, vt[v].re, vt[v].txreq, vt[v].rxwe, vt[v].clr};
            host_addr = vt[v].addr;
            tx_last_idx = vt[v].last;
            host_wdata = vt[v].wdata;
            eng_rx_data = vt[v].rxd;
            tick();
            chk($sformatf("vec%0d_rdata", v), host_rdata, vt[v].x_rdata);
            chk($sformatf("vec%0d_rvalid", v), host_rvalid, vt[v].x_rv);
            chk($sformatf("vec%0d_herr", v), host_err, vt[v].x_herr);
            chk($sformatf("vec%0d_txv", v), eng_tx_valid, vt[v].x_txv);
            chk($sformatf("vec%0d_txl", v), eng_tx_last, vt[v].x_txl);
            chk($sformatf("vec%0d_eerr", v), eng_err, vt[v].x_eerr);
            chk($sformatf("vec%0d_txd", v), eng_tx_data, vt[v].x_txd);
            chk($sformatf("vec%0d_cnt", v), rx_count, vt[v].x_cnt);
        end
        idle();
        hold_ctrl = 1'b1;
        eng_ptr_clr = 1'b1;
        tick();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            eng_rx_we = 1'b1;
            eng_rx_data = 8'hA0 + 8'(i);
            tick();
        end
        idle();
        chk("fill_count", rx_count, 6'd32);
        chk("fill_ovf", rx_ovf, 1'b0);
        host_re = 1'b1;
        host_addr = 5'd5;
        tick();
        chk("fill_entry5", host_rdata, 32'h0000_00A5);
        idle();
        eng_rx_we = 1'b1;
        eng_rx_data = 8'hFF;
        tick();
        idle();
        chk("ovf_set", rx_ovf, 1'b1);
        chk("ovf_count_sat", rx_count, 6'd32);
        host_re = 1'b1;
        host_addr = 5'd0;
        tick();
        chk("ovf_entry0", host_rdata, 32'hFF);
        idle();
        eng_ptr_clr = 1'b1;
        eng_tx_req = 1'b1;
        tick();
        chk("clr_no_txv", eng_tx_valid, 1'b0);
        chk("clr_ovf", rx_ovf, 1'b0);
        chk("clr_count", rx_count, 6'd0);
        idle();
        eng_tx_req = 1'b1;
        tx_last_idx = 5'd0;
        tick();
        chk("clr_txptr0", eng_tx_data, 8'hFF);
        chk("clr_txlast", eng_tx_last, 1'b1);
        idle();
        eng_ptr_clr = 1'b1;
        tick();
        idle();
        hold_ctrl = 1'b0;
        host_we = 1'b1;
        host_addr = 5'd7;
        host_wdata = 32'h5C;
        tick();
        idle();
        hold_ctrl = 1'b1;
        for (int i = 0; i < 7; i++) begin
            {eng_tx_req, eng_rx_we} = 2'b11;
            eng_rx_data = 8'(i);
            tick();
        end
        {eng_tx_req, eng_rx_we, host_re} = 3'b111;
        eng_rx_data = 8'h99;
        host_addr = 5'd7;
        tick();
        chk("coll_txd_old", eng_tx_data, 8'h5C);
        chk("coll_host_old", host_rdata, 32'h5C);
        idle();
        host_re = 1'b1;
        tick();
        chk("coll_entry7_new", host_rdata, 32'h99);
        idle();
        eng_tx_req = 1'b1;
        tick();
        chk("pre_rst_txv", eng_tx_valid, 1'b1);
        idle();
        rst = 1'b1;
        #1;
        chk("rst_masks_txv", eng_tx_valid, 1'b0);
        tick();
        chk("rst_rdata", host_rdata, 32'h0);
        chk("rst_txd", eng_tx_data, 8'h0);
        chk("rst_count", rx_count, 6'd0);
        rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(99) == 0);
            eng_ptr_clr = ($urandom_range(19) == 0);
            hold_ctrl = 1'($urandom);
            host_we = 1'($urandom);
            host_re = 1'($urandom);
            eng_tx_req = 1'($urandom);
            eng_rx_we = ($urandom_range(3) != 0);
            host_addr = 5'($urandom);
            tx_last_idx = 5'($urandom);
            host_wdata = $urandom;
            eng_rx_data = 8'($urandom);
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_data_bank.md
# spi_data_bank

Parametrised shared data memory between the host/control side and the SPI byte engine. It is the multi-entry successor to the single-address SPI data register. It adds independent auto-incrementing TX and RX pointers, registered reads, an ownership mode with access-violation reporting, RX fill count and a sticky overflow flag. The host fills TX words and reads received bytes. The SPI engine streams bytes out of and into the bank without issuing addresses.

## Interface
Parameters:
- DEPTH, 32, number of entries (power of two, ≥4)
- DW, 32, entry width
- SW, 8, serial byte width (SW ≤ DW)
- AW, $clog2(DEPTH), address/pointer width

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- hold_ctrl  in  1  ownership: 0 = host owns writes, 1 = engine owns
- host_addr  in  AW  host entry address
- host_we  in  1  host write strobe
- host_wdata  in  DW  host write data
- host_re  in  1  host read strobe
- host_rdata  out  DW  registered read data
- host_rvalid  out  1  one-cycle pulse; host_rdata valid
- host_err  out  1  one-cycle pulse; host write rejected
- eng_ptr_clr  in  1  clear both pointers, rx_count and rx_ovf
- eng_tx_req  in  1  request next TX byte
- eng_tx_data  out  SW  TX byte (low SW bits of entry)
- eng_tx_valid  out  1  one-cycle pulse; eng_tx_data valid
- eng_tx_last  out  1  qualifies eng_tx_valid; byte came from tx_last_idx
- tx_last_idx  in  AW  index of final TX entry
- eng_rx_we  in  1  write received byte
- eng_rx_data  in  SW  received byte
- eng_err  out  1  one-cycle pulse; engine access rejected
- rx_count  out  AW+1  bytes received since clear, saturates at DEPTH
- rx_ovf  out  1  sticky overflow flag

## Operation
- Storage: DEPTH×DW entries, plus tx_ptr and rx_ptr (AW bits each).
- Host read: always permitted, regardless of hold_ctrl.
- Host write: accepted only when hold_ctrl=0. It writes entry[host_addr] ← host_wdata. When hold_ctrl=1, the write is ignored and host_err pulses.
- Engine TX: accepted only when hold_ctrl=1.
  - Captures entry[tx_ptr][SW-1:0] into eng_tx_data.
  - eng_tx_last = (tx_ptr == tx_last_idx).
  - tx_ptr increments, wrapping DEPTH-1 → 0.
- Engine RX: accepted only when hold_ctrl=1.
  - Writes entry[rx_ptr] ← zero-extended eng_rx_data, then rx_ptr increments with wrap.
  - rx_count increments, saturating at DEPTH.
  - If rx_count == DEPTH before the write, the write still occurs (overwrites oldest) and rx_ovf is set.
- Engine request while hold_ctrl=0: ignored, no pointer or count change, eng_err pulses. A simultaneous tx_req and rx_we while hold_ctrl=0 produces a single eng_err pulse.
- eng_ptr_clr: clears tx_ptr, rx_ptr, rx_count and rx_ovf. It is honoured in either ownership mode. Entry contents are unchanged.
- Collisions:
  - tx_req and rx_we in the same cycle: both are serviced. If tx_ptr == rx_ptr, TX returns the old value (read-before-write).
  - eng_ptr_clr together with tx_req or rx_we: clear wins and the requests are dropped. There is no valid pulse and no err pulse.
  - Host read and engine RX write to the same entry in the same cycle: the host gets the old value.
  - hold_ctrl toggling between transactions is legal. The pointers keep their values.

## Timing
- Reset: all entries 0, and every pointer, count and flag 0. host_rdata, eng_tx_data and all pulses are 0. rst overrides every other input in that cycle.
- Writes (host or engine) take effect at the clk edge where the strobe is sampled.
- Host read: host_re sampled at edge N gives host_rdata/host_rvalid during cycle N+1. host_rdata holds its value until the next accepted read.
- TX: eng_tx_req sampled at edge N gives eng_tx_data/eng_tx_valid/eng_tx_last during N+1. Back-to-back requests every cycle are supported, one byte per cycle.
- rx_count and rx_ovf update at the same edge as the RX write.
- host_err and eng_err are asserted during the cycle after the rejected strobe, for one cycle.
- Mid-operation reset: outstanding valid pulses are suppressed, and the next cycle shows reset values.

## Test plan
- Reset, then host reads addresses 0..DEPTH-1 → every host_rdata = 0, with host_rvalid one cycle after each host_re.
- hold_ctrl=0: host writes 0x11,0x22,0x33 to entries 0..2. Set tx_last_idx=2, hold_ctrl=1, then issue 3 consecutive tx_req → eng_tx_data 0x11,0x22,0x33 on consecutive cycles, with eng_tx_last only on 0x33 and tx_ptr=3.
- hold_ctrl=1: send 32 rx_we of 0xA0+i → rx_count=32, rx_ovf=0, and host reads entry 5 = 0x000000A5. A 33rd write of 0xFF → entry 0 = 0xFF, rx_ovf=1, rx_count stays 32.
- hold_ctrl=1 with host_we to entry 4 → host_err pulse and entry 4 unchanged. hold_ctrl=0 with eng_rx_we → eng_err pulse, rx_count unchanged.
- With tx_ptr = rx_ptr = 7 and entry 7 = 0x5C, issue tx_req and rx_we 0x99 together → eng_tx_data=0x5C, then entry 7 = 0x99.
- Assert eng_ptr_clr together with tx_req → no eng_tx_valid, pointers 0, rx_ovf cleared. Assert rst in the cycle after a tx_req → eng_tx_valid suppressed and all outputs 0.
